// File: rtl/lc3_alu_issue_if.sv
// Instruction issue handshake between the fetch side and the LC-3 ALU issue stage.
interface lc3_alu_issue_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/lc3_alu_issue.sv
// LC-3 decode/issue stage: decodes ADD/AND/NOT, drives the ALU execute stage
// and returns its registered result to writeback with NZP condition codes.
module lc3_alu_issue #(
  parameter logic [2:0] RESET_NZP = 3'b010
) (
  input  logic                clock,
  input  logic                reset,
  lc3_alu_issue_if.slave      ifc,
  output logic [2:0]          sr1_addr,
  output logic [2:0]          sr2_addr,
  input  logic [15:0]         sr1_data,
  input  logic [15:0]         sr2_data,
  output logic [15:0]         aluin1,
  output logic [15:0]         aluin2,
  output logic [1:0]          alu_control,
  output logic                enable_execute,
  input  logic [15:0]         aluout,
  input  logic                alucarry,
  output logic                wb_valid,
  output logic [2:0]          wb_dr,
  output logic [15:0]         wb_data,
  output logic                wb_carry,
  output logic [2:0]          wb_nzp,
  output logic [2:0]          cc_nzp,
  output logic                illegal
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IMM_W  = 5;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [1:0] CTL_ADD = 2'd0;
  localparam logic [1:0] CTL_AND = 2'd1;
  localparam logic [1:0] CTL_NOT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   imm_sext;
  logic [DATA_W-1:0]   operand2;

  assign imm_sext = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign operand2 = ir[5] ? imm_sext : sr2_data;

  assign sr1_addr = ir[8:6];
  assign sr2_addr = ir[2:0];

  // The idle cycle that carries the illegal pulse is held off so a rejected
  // opcode still occupies three cycles from accept to the next ready.
  assign ifc.instr_ready = (state == IDLE) && !illegal;

  assign wb_valid = (state == WB);
  assign wb_dr    = ir[11:9];
  assign wb_data  = aluout;
  assign wb_carry = alucarry;
  assign wb_nzp   = aluout[DATA_W-1]      ? 3'b100 :
                    (aluout == '0)        ? 3'b010 : 3'b001;

  // Issue FSM with registered ALU-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      ir             <= '0;
      aluin1         <= '0;
      aluin2         <= '0;
      alu_control    <= CTL_ADD;
      enable_execute <= 1'b0;
      illegal        <= 1'b0;
      cc_nzp         <= RESET_NZP;
    end else begin
      enable_execute <= 1'b0;
      illegal        <= 1'b0;
      case (state)
        IDLE: begin
          if (ifc.instr_valid && ifc.instr_ready) begin
            ir    <= ifc.instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          case (ir[15:12])
            OP_ADD: begin
              alu_control    <= CTL_ADD;
              aluin1         <= sr1_data;
              aluin2         <= operand2;
              enable_execute <= 1'b1;
              state          <= EXEC;
            end
            OP_AND: begin
              alu_control    <= CTL_AND;
              aluin1         <= sr1_data;
              aluin2         <= operand2;
              enable_execute <= 1'b1;
              state          <= EXEC;
            end
            OP_NOT: begin
              alu_control    <= CTL_NOT;
              aluin1         <= sr1_data;
              aluin2         <= '0;
              enable_execute <= 1'b1;
              state          <= EXEC;
            end
            default: begin
              illegal <= 1'b1;
              state   <= IDLE;
            end
          endcase
        end
        EXEC: begin
          state <= WB;
        end
        WB: begin
          cc_nzp <= wb_nzp;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lc3_alu_issue.md
Name: lc3_alu_issue

Overview:
Decode/issue stage that drives the LC-3 ALU execute stage. It accepts one instruction at a time over a valid/ready handshake and decodes ADD, AND and NOT. It reads the register file, forms the ALU operands and alu_control, and pulses enable_execute for one cycle. It then returns the ALU's registered result to writeback with the destination register and updates the NZP condition codes.

Parameters:
RESET_NZP, 3'b010, value loaded into cc_nzp on reset (Z set).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high.
instr_valid  input  1  instr holds a valid instruction.
instr_ready  output  1  high only in IDLE; accept = instr_valid & instr_ready at a rising edge.
instr  input  16  LC-3 instruction word.
sr1_addr  output  3  register file read address 1 = IR[8:6].
sr2_addr  output  3  register file read address 2 = IR[2:0].
sr1_data  input  16  combinational read data for sr1_addr.
sr2_data  input  16  combinational read data for sr2_addr.
aluin1  output  16  registered ALU operand 1.
aluin2  output  16  registered ALU operand 2.
alu_control  output  2  0=ADD, 1=AND, 2=NOT.
enable_execute  output  1  one-cycle pulse; the ALU captures its result at the end of this cycle.
aluout  input  16  ALU registered result.
alucarry  input  1  ALU registered carry.
wb_valid  output  1  one-cycle pulse: wb_dr/wb_data/wb_carry/wb_nzp are valid.
wb_dr  output  3  destination register = IR[11:9].
wb_data  output  16  equals aluout while wb_valid is high.
wb_carry  output  1  equals alucarry while wb_valid is high.
wb_nzp  output  3  N/Z/P computed from aluout; exactly one bit set.
cc_nzp  output  3  registered condition codes; updated on the edge that ends the WB state.
illegal  output  1  one-cycle pulse when the opcode is not ADD/AND/NOT.

Behaviour:
- Reset (synchronous, active-high, clock): state=IDLE; IR, aluin1, aluin2 = 0; alu_control=0; enable_execute, wb_valid, illegal = 0; cc_nzp=RESET_NZP. A reset in any state aborts the instruction with no writeback. The ALU is reset by the same signal.
- Outputs to the ALU (aluin1, aluin2, alu_control, enable_execute) are registers. wb_* outputs are combinational from state, IR and the ALU outputs.
- FSM states: IDLE, DECODE, EXEC, WB.
- IDLE: instr_ready=1. On accept, IR<=instr and state goes to DECODE.
- DECODE: instr_ready=0. sr1_addr/sr2_addr are driven from IR. Decode on IR[15:12]:
  - ADD (4'b0001): alu_control<=0.
  - AND (4'b0101): alu_control<=1.
  - For ADD/AND: aluin1<=sr1_data. aluin2<=sign-extended IR[4:0] if IR[5]=1, else sr2_data.
  - NOT (4'b1001): alu_control<=2; aluin1<=sr1_data; aluin2<=0. IR[5:0] is not checked.
  - Legal opcode: go to EXEC.
  - Any other opcode: illegal=1 for the next cycle, state goes to IDLE. No enable_execute, no wb_valid, cc_nzp unchanged. aluin and alu_control are unchanged.
- EXEC: enable_execute=1 for exactly this cycle; aluin/alu_control are stable. Go to WB.
- WB: wb_valid=1; wb_data=aluout; wb_carry=alucarry.
  - wb_nzp: N=aluout[15]; Z=(aluout==0); P=otherwise.
  - cc_nzp<=wb_nzp at the edge that ends WB; state goes to IDLE.
- Latency: accept edge to wb_valid is 3 cycles. Throughput is one instruction per 4 cycles with instr_valid held high, one per 3 cycles for illegal opcodes.
- Hazards: the register-file write of wb_data occurs at the end of WB, before the next DECODE. Dependent back-to-back instructions therefore read updated values with no forwarding.
- instr is sampled only on accept; changes to instr at other times are ignored.
- Arithmetic is 16-bit modulo. Carry comes from the ALU and is passed through only; it does not affect cc_nzp.

Test Plan:
- ADD R1,R2,#-3 (instr=16'h12BD) with R2=16'h0005 -> DECODE reads sr1_addr=2; aluin1=16'h0005, aluin2=16'hFFFD, alu_control=0; enable_execute is one cycle; next cycle wb_valid=1, wb_dr=1, wb_data=16'h0002, wb_carry=1, wb_nzp=3'b001; then cc_nzp=3'b001.
- AND R3,R4,R5 (16'h5705) with R4=16'h00F0, R5=16'h0FF0 -> alu_control=1, aluin2=16'h0FF0, wb_data=16'h00F0, wb_dr=3, wb_nzp=3'b001.
- NOT R0,R7 (16'h91FF) with R7=16'hFFFF -> alu_control=2, aluin2=0, wb_data=16'h0000, wb_nzp=3'b010; then ADD R0,R0,#-1 (16'h103F) -> wb_data=16'hFFFF, wb_nzp=3'b100, cc_nzp=3'b100.
- Illegal 16'h0E05 (BR) -> illegal pulses 1 cycle after DECODE; enable_execute and wb_valid stay 0; cc_nzp is unchanged; instr_ready returns 3 cycles after accept.
- Reset asserted during EXEC -> all outputs as in reset next cycle, cc_nzp=3'b010, no wb_valid; instr_ready=1 on the first cycle after reset deasserts.
- instr_valid held high with 3 ADDs -> accepts spaced exactly 4 cycles apart; instr_ready is 0 in DECODE/EXEC/WB; the dependent ADD R1,R1,#1 sees the updated R1.
